// File: rtl/tcpc_tx_pkg.sv
// Shared types and constants for the TCPC transmit request path.
package tcpc_tx_pkg;

  localparam int unsigned FRAME_TYPE_W = 3;
  localparam int unsigned RETRY_W      = 2;
  localparam int unsigned TX_RETRY_W   = 8;
  localparam int unsigned WD_W         = 16;

  localparam logic [FRAME_TYPE_W-1:0] FT_SOP         = 3'd0;
  localparam logic [FRAME_TYPE_W-1:0] FT_SOP_P       = 3'd1;
  localparam logic [FRAME_TYPE_W-1:0] FT_SOP_PP      = 3'd2;
  localparam logic [FRAME_TYPE_W-1:0] FT_DBG_P       = 3'd3;
  localparam logic [FRAME_TYPE_W-1:0] FT_DBG_PP      = 3'd4;
  localparam logic [FRAME_TYPE_W-1:0] FT_HARD_RESET  = 3'd5;
  localparam logic [FRAME_TYPE_W-1:0] FT_CABLE_RESET = 3'd6;
  localparam logic [FRAME_TYPE_W-1:0] FT_BIST_CM2    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE_GCRC = 3'd1,
    ST_WAIT_GCRC  = 3'd2,
    ST_ISSUE_MSG  = 3'd3,
    ST_WAIT_MSG   = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic                    valid;
    logic [FRAME_TYPE_W-1:0] frame_type;
    logic [RETRY_W-1:0]      retry;
  } tx_slot_t;

  // SOP* and debug frames yield to an incoming message; resets never do.
  function automatic logic is_discardable(input logic [FRAME_TYPE_W-1:0] frame_type);
    return (frame_type <= FT_DBG_PP);
  endfunction

endpackage

// File: rtl/tx_watchdog.sv
// Completion watchdog: counts WAIT cycles and flags when the limit is reached.
module tx_watchdog
  import tcpc_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic timeout_c
);

  logic [WD_W-1:0] count;

  // Saturates so an unattended counter can never wrap back below the limit.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WD_W'(1);
    end
  end

  assign timeout_c = enable && (count == WD_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/tx_request_arbiter.sv
// Shares the transmit engine between GoodCRC replies and TCPM TRANSMIT requests,
// and converts engine outcomes into TCPM transmit alerts.
module tx_request_arbiter
  import tcpc_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    GoodCRCReq,
  input  logic [FRAME_TYPE_W-1:0] GoodCRCType,
  output logic                    GoodCRCAck,
  input  logic                    TransmitWrite,
  input  logic [15:0]             TRANSMIT,
  input  logic                    RxMessageReceived,
  output logic                    TxStart,
  output logic [FRAME_TYPE_W-1:0] TxFrameType,
  output logic                    TxIsGoodCRC,
  output logic [TX_RETRY_W-1:0]   TxRetryCount,
  input  logic                    TxSuccess,
  input  logic                    TxFailed,
  output logic                    Alert_TransmitSuccessful,
  output logic                    Alert_TransmitFailed,
  output logic                    Alert_TransmitDiscarded,
  output logic                    Busy
);

  tx_state_e state, state_d;
  tx_slot_t  slot, slot_d;

  logic                    ack_d;
  logic                    start_d;
  logic [FRAME_TYPE_W-1:0] frame_type_d;
  logic                    is_gcrc_d;
  logic [TX_RETRY_W-1:0]   retry_d;
  logic                    alert_succ_d;
  logic                    alert_fail_d;
  logic                    alert_disc_d;
  logic                    busy_d;

  logic discard_hit;
  logic wd_timeout;
  logic wd_clear;
  logic wd_enable;

  logic [10:0] unused_transmit_bits;
  assign unused_transmit_bits = {TRANSMIT[15:6], TRANSMIT[3]};

  assign wd_clear  = (state == ST_ISSUE_GCRC) || (state == ST_ISSUE_MSG);
  assign wd_enable = (state == ST_WAIT_GCRC) || (state == ST_WAIT_MSG);

  tx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .timeout_c(wd_timeout)
  );

  // A pending entry that is discarded this cycle must not also be issued.
  assign discard_hit = RxMessageReceived && slot.valid && is_discardable(slot.frame_type);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d      = state;
    slot_d       = slot;
    ack_d        = 1'b0;
    start_d      = 1'b0;
    frame_type_d = TxFrameType;
    is_gcrc_d    = TxIsGoodCRC;
    retry_d      = TxRetryCount;
    alert_succ_d = 1'b0;
    alert_fail_d = 1'b0;
    alert_disc_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (GoodCRCReq) begin
          state_d      = ST_ISSUE_GCRC;
          ack_d        = 1'b1;
          start_d      = 1'b1;
          is_gcrc_d    = 1'b1;
          frame_type_d = GoodCRCType;
          retry_d      = '0;
        end else if (slot.valid && !discard_hit) begin
          state_d      = ST_ISSUE_MSG;
          start_d      = 1'b1;
          is_gcrc_d    = 1'b0;
          frame_type_d = slot.frame_type;
          retry_d      = {6'b0, slot.retry};
          slot_d.valid = 1'b0;
        end
      end
      ST_ISSUE_GCRC: state_d = ST_WAIT_GCRC;
      ST_ISSUE_MSG:  state_d = ST_WAIT_MSG;
      ST_WAIT_GCRC: begin
        if (TxSuccess || TxFailed || wd_timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_MSG: begin
        if (TxSuccess) begin
          alert_succ_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (TxFailed || wd_timeout) begin
          alert_fail_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (discard_hit) begin
      slot_d.valid = 1'b0;
      alert_disc_d = 1'b1;
    end

    // New write lands after any discard/issue of the old entry.
    if (TransmitWrite) begin
      if (TRANSMIT[2:0] == FT_BIST_CM2) begin
        alert_fail_d = 1'b1;
      end else begin
        if (slot_d.valid) begin
          alert_disc_d = 1'b1;
        end
        slot_d.valid      = 1'b1;
        slot_d.frame_type = TRANSMIT[2:0];
        slot_d.retry      = TRANSMIT[5:4];
      end
    end

    busy_d = (state_d != ST_IDLE) || slot_d.valid;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      slot                     <= '0;
      GoodCRCAck               <= 1'b0;
      TxStart                  <= 1'b0;
      TxFrameType              <= '0;
      TxIsGoodCRC              <= 1'b0;
      TxRetryCount             <= '0;
      Alert_TransmitSuccessful <= 1'b0;
      Alert_TransmitFailed     <= 1'b0;
      Alert_TransmitDiscarded  <= 1'b0;
      Busy                     <= 1'b0;
    end else begin
      slot                     <= slot_d;
      GoodCRCAck               <= ack_d;
      TxStart                  <= start_d;
      TxFrameType              <= frame_type_d;
      TxIsGoodCRC              <= is_gcrc_d;
      TxRetryCount             <= retry_d;
      Alert_TransmitSuccessful <= alert_succ_d;
      Alert_TransmitFailed     <= alert_fail_d;
      Alert_TransmitDiscarded  <= alert_disc_d;
      Busy                     <= busy_d;
    end
  end

endmodule

// File: tb/tb_tx_request_arbiter.sv
// Directed bench for tx_request_arbiter: per-cycle vector table plus hand sequences.
module tb_tx_request_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        GoodCRCReq;
  logic [2:0]  GoodCRCType;
  logic        GoodCRCAck;
  logic        TransmitWrite;
  logic [15:0] TRANSMIT;
  logic        RxMessageReceived;
  logic        TxStart;
  logic [2:0]  TxFrameType;
  logic        TxIsGoodCRC;
  logic [7:0]  TxRetryCount;
  logic        TxSuccess;
  logic        TxFailed;
  logic        Alert_TransmitSuccessful;
  logic        Alert_TransmitFailed;
  logic        Alert_TransmitDiscarded;
  logic        Busy;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  tx_request_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .GoodCRCReq              (GoodCRCReq),
    .GoodCRCType             (GoodCRCType),
    .GoodCRCAck              (GoodCRCAck),
    .TransmitWrite           (TransmitWrite),
    .TRANSMIT                (TRANSMIT),
    .RxMessageReceived       (RxMessageReceived),
    .TxStart                 (TxStart),
    .TxFrameType             (TxFrameType),
    .TxIsGoodCRC             (TxIsGoodCRC),
    .TxRetryCount            (TxRetryCount),
    .TxSuccess               (TxSuccess),
    .TxFailed                (TxFailed),
    .Alert_TransmitSuccessful(Alert_TransmitSuccessful),
    .Alert_TransmitFailed    (Alert_TransmitFailed),
    .Alert_TransmitDiscarded (Alert_TransmitDiscarded),
    .Busy                    (Busy)
  );

  // {ack, start, type[2:0], is_gcrc, retry[7:0], succ, fail, disc, busy}
  logic [17:0] obs;
  assign obs = {GoodCRCAck, TxStart, TxFrameType, TxIsGoodCRC, TxRetryCount,
                Alert_TransmitSuccessful, Alert_TransmitFailed, Alert_TransmitDiscarded, Busy};

  typedef struct {
    string       name;
    logic        req;
    logic [2:0]  gtype;
    logic        tw;
    logic [15:0] tr;
    logic        rx;
    logic        succ;
    logic        fail;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] ex(input logic ack, input logic start, input logic [2:0] ft,
                                     input logic isg, input logic [7:0] rc, input logic as,
                                     input logic af, input logic ad, input logic busy);
    return {ack, start, ft, isg, rc, as, af, ad, busy};
  endfunction

  function automatic void add(input string name, input logic req, input logic [2:0] gtype,
                              input logic tw, input logic [15:0] tr, input logic rx,
                              input logic succ, input logic fail, input logic [17:0] exp);
    vec_t v;
    v.name = name; v.req = req; v.gtype = gtype; v.tw = tw; v.tr = tr;
    v.rx = rx; v.succ = succ; v.fail = fail; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic req, input logic [2:0] gtype, input logic tw,
                       input logic [15:0] tr, input logic rx, input logic succ, input logic fail);
    GoodCRCReq = req; GoodCRCType = gtype; TransmitWrite = tw; TRANSMIT = tr;
    RxMessageReceived = rx; TxSuccess = succ; TxFailed = fail;
  endtask

  task automatic check(input string name, input logic [17:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h", name, obs, exp);
    end
  endtask

  task automatic step(input string name, input logic [17:0] exp);
    @(posedge Clock);
    @(negedge Clock);
    check(name, exp);
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 16'h0000, 0, 0, 0);
    repeat (2) @(negedge Clock);
    check("reset_state", 18'h0);
    Reset = 1'b0;

    add("gcrc_issue",        1, 1, 0, 16'h0000, 0, 0, 0, ex(1,1,1,1,0,0,0,0,1));
    add("gcrc_wait",         0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,1,1,0,0,0,0,1));
    add("gcrc_done",         0, 0, 0, 16'h0000, 0, 1, 0, ex(0,0,1,1,0,0,0,0,0));
    add("gcrc_idle",         0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,1,1,0,0,0,0,0));
    add("msg_load",          0, 0, 1, 16'h0030, 0, 0, 0, ex(0,0,1,1,0,0,0,0,1));
    add("msg_issue",         0, 0, 0, 16'h0000, 0, 0, 0, ex(0,1,0,0,3,0,0,0,1));
    add("msg_wait",          0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,0,0,3,0,0,0,1));
    add("msg_succ",          0, 0, 0, 16'h0000, 0, 1, 0, ex(0,0,0,0,3,1,0,0,0));
    add("msg_idle",          0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,0,0,3,0,0,0,0));
    add("tie_gcrc",          1, 2, 1, 16'h0011, 0, 0, 0, ex(1,1,2,1,0,0,0,0,1));
    add("tie_gcrc_wait",     0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,2,1,0,0,0,0,1));
    add("tie_gcrc_done",     0, 0, 0, 16'h0000, 0, 1, 0, ex(0,0,2,1,0,0,0,0,1));
    add("tie_msg_issue",     0, 0, 0, 16'h0000, 0, 0, 0, ex(0,1,1,0,1,0,0,0,1));
    add("tie_msg_wait",      0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,1,0,1,0,0,0,1));
    add("tie_msg_fail",      0, 0, 0, 16'h0000, 0, 0, 1, ex(0,0,1,0,1,0,1,0,0));
    add("disc_gcrc",         1, 0, 0, 16'h0000, 0, 0, 0, ex(1,1,0,1,0,0,0,0,1));
    add("disc_load",         0, 0, 1, 16'h0020, 0, 0, 0, ex(0,0,0,1,0,0,0,0,1));
    add("disc_rx",           0, 0, 0, 16'h0000, 1, 0, 0, ex(0,0,0,1,0,0,0,1,1));
    add("disc_gcrc_fail",    0, 0, 0, 16'h0000, 0, 0, 1, ex(0,0,0,1,0,0,0,0,0));
    add("disc_no_start",     0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,0,1,0,0,0,0,0));
    add("hr_gcrc",           1, 3, 0, 16'h0000, 0, 0, 0, ex(1,1,3,1,0,0,0,0,1));
    add("hr_load",           0, 0, 1, 16'h0015, 0, 0, 0, ex(0,0,3,1,0,0,0,0,1));
    add("hr_rx_kept",        0, 0, 0, 16'h0000, 1, 0, 0, ex(0,0,3,1,0,0,0,0,1));
    add("hr_gcrc_done",      0, 0, 0, 16'h0000, 0, 1, 0, ex(0,0,3,1,0,0,0,0,1));
    add("hr_issue",          0, 0, 0, 16'h0000, 0, 0, 0, ex(0,1,5,0,1,0,0,0,1));
    add("hr_wait",           0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,5,0,1,0,0,0,1));
    add("hr_succ",           0, 0, 0, 16'h0000, 0, 1, 0, ex(0,0,5,0,1,1,0,0,0));
    add("bist_reject",       0, 0, 1, 16'h0007, 0, 0, 0, ex(0,0,5,0,1,0,1,0,0));
    add("bist_no_start",     0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,5,0,1,0,0,0,0));
    add("rep_gcrc",          1, 1, 0, 16'h0000, 0, 0, 0, ex(1,1,1,1,0,0,0,0,1));
    add("rep_load",          0, 0, 1, 16'h0002, 0, 0, 0, ex(0,0,1,1,0,0,0,0,1));
    add("rep_replace",       0, 0, 1, 16'h0013, 0, 0, 0, ex(0,0,1,1,0,0,0,1,1));
    add("rep_rx_and_write",  0, 0, 1, 16'h0024, 1, 0, 0, ex(0,0,1,1,0,0,0,1,1));
    add("rep_gcrc_done",     0, 0, 0, 16'h0000, 0, 1, 0, ex(0,0,1,1,0,0,0,0,1));
    add("rep_issue",         0, 0, 0, 16'h0000, 0, 0, 0, ex(0,1,4,0,2,0,0,0,1));
    add("rep_wait",          0, 0, 0, 16'h0000, 0, 0, 0, ex(0,0,4,0,2,0,0,0,1));
    add("rep_both_outcomes", 0, 0, 0, 16'h0000, 0, 1, 1, ex(0,0,4,0,2,1,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].gtype, vecs[i].tw, vecs[i].tr, vecs[i].rx,
            vecs[i].succ, vecs[i].fail);
      step(vecs[i].name, vecs[i].exp);
    end

    // Watchdog: no outcome, limit 4 -> failure 5 cycles after WAIT_MSG entry.
    drive(0, 0, 1, 16'h0000, 0, 0, 0);
    step("to_load", ex(0,0,4,0,2,0,0,0,1));
    drive(0, 0, 0, 16'h0000, 0, 0, 0);
    step("to_issue", ex(0,1,0,0,0,0,0,0,1));
    for (int i = 0; i < 5; i++) step("to_wait", ex(0,0,0,0,0,0,0,0,1));
    step("to_fail", ex(0,0,0,0,0,0,1,0,0));

    // GoodCRC requested during WAIT_MSG goes ahead of the pending slot.
    drive(0, 0, 1, 16'h0001, 0, 0, 0);
    step("gw_load", ex(0,0,0,0,0,0,0,0,1));
    drive(0, 0, 0, 16'h0000, 0, 0, 0);
    step("gw_issue", ex(0,1,1,0,0,0,0,0,1));
    step("gw_wait", ex(0,0,1,0,0,0,0,0,1));
    drive(1, 2, 1, 16'h0002, 0, 0, 0);
    step("gw_req_in_wait", ex(0,0,1,0,0,0,0,0,1));
    drive(1, 2, 0, 16'h0000, 0, 1, 0);
    step("gw_msg_done", ex(0,0,1,0,0,1,0,0,1));
    drive(1, 2, 0, 16'h0000, 0, 0, 0);
    step("gw_gcrc_first", ex(1,1,2,1,0,0,0,0,1));
    drive(0, 0, 0, 16'h0000, 0, 0, 0);
    step("gw_gcrc_wait", ex(0,0,2,1,0,0,0,0,1));
    drive(0, 0, 0, 16'h0000, 0, 1, 0);
    step("gw_gcrc_done", ex(0,0,2,1,0,0,0,0,1));
    drive(0, 0, 0, 16'h0000, 0, 0, 0);
    step("gw_slot_issue", ex(0,1,2,0,0,0,0,0,1));
    step("gw_slot_wait", ex(0,0,2,0,0,0,0,0,1));
    drive(0, 0, 0, 16'h0000, 0, 1, 0);
    step("gw_slot_succ", ex(0,0,2,0,0,1,0,0,0));

    // Reset during WAIT_MSG with a second entry pending.
    drive(0, 0, 1, 16'h0030, 0, 0, 0);
    step("rst_load", ex(0,0,2,0,0,0,0,0,1));
    drive(0, 0, 0, 16'h0000, 0, 0, 0);
    step("rst_issue", ex(0,1,0,0,3,0,0,0,1));
    step("rst_wait", ex(0,0,0,0,3,0,0,0,1));
    drive(0, 0, 1, 16'h0001, 0, 0, 0);
    step("rst_pending", ex(0,0,0,0,3,0,0,0,1));
    drive(0, 0, 0, 16'h0000, 0, 0, 0);
    #2 Reset = 1'b1;
    #1 check("rst_async", 18'h0);
    @(negedge Clock);
    Reset = 1'b0;
    drive(0, 0, 0, 16'h0000, 0, 1, 0);
    step("rst_no_alert", 18'h0);
    drive(0, 0, 0, 16'h0000, 0, 0, 0);
    step("rst_slot_empty", 18'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_request_arbiter.md
# tx_request_arbiter

Sequences and shares the TCPC transmit engine between two requesters: automatic GoodCRC replies from the receive path and TCPM-written TRANSMIT requests. Holds one pending TCPM request, gives GoodCRC strict priority, issues one start pulse per frame to the transmit engine, and turns its success/failure outcome into TCPM-level transmit alerts. It also implements discard-on-receive and a completion watchdog. It sits between the register block / RX path and the transmit engine.

## Interface
- TIMEOUT_CYCLES, 255: cycles in a WAIT state without an outcome before a forced failure; legal range 1..65535.
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- GoodCRCReq  in  1  level; RX needs a GoodCRC sent; held until GoodCRCAck
- GoodCRCType  in  3  SOP type to reply on
- GoodCRCAck  out  1  one-cycle pulse when GoodCRC is issued
- TransmitWrite  in  1  one-cycle pulse; TCPM wrote TRANSMIT
- TRANSMIT  in  16  [2:0] frame type, [5:4] retry count; sampled on TransmitWrite
- RxMessageReceived  in  1  one-cycle pulse; non-GoodCRC message accepted by RX
- TxStart  out  1  one-cycle start pulse to the transmit engine
- TxFrameType  out  3  frame type for the current frame; stable from TxStart to completion
- TxIsGoodCRC  out  1  selects the GoodCRC header source; stable with TxFrameType
- TxRetryCount  out  8  nRetryCount for the engine, {6'b0, retry}; 0 for GoodCRC
- TxSuccess, TxFailed  in  1 each  outcome pulses from the transmit engine
- Alert_TransmitSuccessful, Alert_TransmitFailed, Alert_TransmitDiscarded  out  1 each  one-cycle pulses
- Busy  out  1  state not IDLE or pending slot valid

## Operation
- All outputs are registered. Every output resets to 0.
- Reset puts the FSM in IDLE and clears the pending slot and watchdog.
- Pending slot: valid, type[2:0], retry[1:0].
  - TransmitWrite loads the slot.
  - If the slot is already valid, the old entry is replaced and Alert_TransmitDiscarded pulses.
- Type 7 (BIST carrier) is never loaded. Alert_TransmitFailed pulses on the next cycle.
- FSM states: IDLE, ISSUE_GCRC, WAIT_GCRC, ISSUE_MSG, WAIT_MSG.
  - IDLE → ISSUE_GCRC when GoodCRCReq. Otherwise IDLE → ISSUE_MSG when the slot is valid. GoodCRC wins a tie.
  - ISSUE_GCRC: TxStart=1, GoodCRCAck=1, TxIsGoodCRC=1, TxFrameType=GoodCRCType. Then → WAIT_GCRC.
  - ISSUE_MSG: TxStart=1, drive the slot contents, clear the slot. Then → WAIT_MSG.
  - WAIT_GCRC: TxSuccess, TxFailed or timeout → IDLE. No TCPM alert is raised.
  - WAIT_MSG: TxSuccess → Alert_TransmitSuccessful. TxFailed or timeout → Alert_TransmitFailed. Then → IDLE.
- Discard: on RxMessageReceived, a valid slot holding type 0..4 is cleared and Alert_TransmitDiscarded pulses.
  - Types 5 and 6 (Hard/Cable Reset) are never discarded.
  - A frame already issued (WAIT_MSG) is not affected.
- A TransmitWrite during a WAIT state loads the slot normally. The slot is served after the current frame.
- An in-flight frame is never aborted.
- A GoodCRCReq during WAIT_MSG is served after WAIT_MSG completes, before the slot.
- Simultaneous events in the same cycle:
  - TxSuccess with TxFailed: success wins.
  - TransmitWrite with RxMessageReceived: discard is applied to the old entry first, then the new entry loads. At most one Discarded pulse.
  - An outcome in the same cycle as the timeout: the outcome wins.
- Alerts from different sources in the same cycle may coincide. Each alert is an independent pulse.

## Timing
- Request in cycle N with the FSM in IDLE → ISSUE_* in N+1 → TxStart high in N+1 (registered). WAIT_* from N+2.
- Outcome pulse in cycle M → alert high in M+1, FSM in IDLE at M+1. The next ISSUE is no earlier than M+2.
- Watchdog clears on entry to WAIT_* and counts each WAIT cycle. Count == TIMEOUT_CYCLES is treated as TxFailed.
- Tx* outputs hold their values until the next ISSUE.
- Reset mid-frame: outputs drop asynchronously. No alert is emitted for the aborted frame.

## Structure
- Package tcpc_tx_pkg holds:
  - frame type constants: SOP=0, SOP'=1, SOP''=2, DBG'=3, DBG''=4, HARD_RESET=5, CABLE_RESET=6, BIST_CM2=7
  - FSM state encoding
  - the is_discardable() function
- Sub-module tx_watchdog: 16-bit counter with clear/enable and a timeout flag.

## Test plan
- GoodCRCReq with GoodCRCType=1 → TxStart, GoodCRCAck and TxIsGoodCRC together with TxFrameType=1; TxSuccess → no TCPM alert, Busy falls.
- TransmitWrite TRANSMIT=16'h0030 → TxStart with type 0 and TxRetryCount=3; TxSuccess → Alert_TransmitSuccessful one cycle later.
- GoodCRCReq and TransmitWrite in the same cycle → GoodCRC issued first; message TxStart 2 cycles after the GoodCRC outcome.
- Slot holds type 0 and RxMessageReceived → Discarded pulse, no TxStart. Repeat with type 5 → no discard; Hard Reset issued.
- TIMEOUT_CYCLES=4 with no outcome → Alert_TransmitFailed on the 5th cycle after entering WAIT_MSG. TRANSMIT type 7 → immediate Failed, no TxStart.
- Reset asserted during WAIT_MSG → all outputs 0 asynchronously; after release, IDLE with the slot empty.
